// File: rtl/core_ifu_if.sv
// core_ifu_if: groups the fetch unit's redirect/stall inputs, its instruction
// memory request/response channel and its decode-side valid/ready channel.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. On the memory request channel valid
// may be withdrawn without a transfer (stall or redirect). Memory responses
// carry no ready: mem_resp_valid_in is a one-cycle pulse per word, in request
// order.
//
// Modports:
//   master - the fetch unit (drives *_out, samples *_in)
//   slave  - the surrounding pipeline/memory (drives *_in, samples *_out)
interface core_ifu_if;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic        hold_flag_in;
  logic        mem_req_valid_out;
  logic [31:0] mem_req_addr_out;
  logic        mem_req_ready_in;
  logic        mem_resp_valid_in;
  logic [31:0] mem_resp_data_in;
  logic        inst_valid_out;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;
  logic        inst_ready_in;
  logic        fault_out;

  modport master (
    input  jump_flag_in, jump_addr_in, hold_flag_in,
    output mem_req_valid_out, mem_req_addr_out,
    input  mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
    output inst_valid_out, inst_out, inst_addr_out,
    input  inst_ready_in,
    output fault_out
  );

  modport slave (
    output jump_flag_in, jump_addr_in, hold_flag_in,
    input  mem_req_valid_out, mem_req_addr_out,
    output mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
    input  inst_valid_out, inst_out, inst_addr_out,
    output inst_ready_in,
    input  fault_out
  );
endinterface

// File: rtl/core_ifu.sv
// core_ifu: instruction fetch unit. Generates the PC, issues in-order fetch
// requests, buffers returned words with their addresses in a prefetch FIFO
// and presents the FIFO head to decode. A jump flushes buffered words and
// marks every in-flight fetch to be dropped when it returns.
//
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous reset, active-high
//   bus  - core_ifu_if.master: redirect/hold, memory request/response,
//          decode valid/ready, fault_out
//
// Parameters:
//   RESET_PC   - first fetch address after reset
//   FIFO_DEPTH - prefetch entries (power of 2, >= 2); also caps
//                buffered + outstanding fetches, so the FIFO cannot overflow
//
// Optional feature macro: CORE_IFU_ALIGN_CHECK_EN
//   defined   - a jump to an address with [1:0] != 0 sets a sticky fault_out;
//               fetching stops until reset
//   undefined - jump target low bits are forced to 0, fault_out is 0
module core_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        rst,
  core_ifu_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  logic [31:0]   pc_q;
  logic [31:0]   resp_pc_q;
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic [31:0]   fifo_addr_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_q;
  logic [CW:0]   credit_sum;
  logic          fault_q;

  logic          credit_ok;
  logic          req_valid;
  logic          req_fire;
  logic          resp_fire;
  logic          push;
  logic          inst_valid;
  logic          pop;
  logic [31:0]   jump_target;
  logic          misaligned;

`ifdef CORE_IFU_ALIGN_CHECK_EN
  assign jump_target = bus.jump_addr_in;
  assign misaligned  = bus.jump_flag_in & (bus.jump_addr_in[1:0] != 2'b00);
`else
  logic unused_jump_lsbs;
  assign unused_jump_lsbs = ^bus.jump_addr_in[1:0];
  assign jump_target      = {bus.jump_addr_in[31:2], 2'b00};
  assign misaligned       = 1'b0;
`endif

  // Words still in flight hold a FIFO slot in reserve, including ones that
  // will be dropped after a jump; this is what makes overflow impossible.
  assign credit_sum = {1'b0, count_q} + {1'b0, outstanding_q};
  assign credit_ok  = credit_sum < DEPTH_C;

  assign req_valid = !rst & !bus.hold_flag_in & !bus.jump_flag_in & credit_ok & !fault_q;
  assign req_fire  = req_valid & bus.mem_req_ready_in;
  assign resp_fire = bus.mem_resp_valid_in;

  // A returning word is kept only if it is not owed to an earlier redirect
  // and no redirect is happening in this same cycle.
  assign push = resp_fire & (drop_q == '0) & !bus.jump_flag_in;

  assign inst_valid = !rst & (count_q != '0) & !bus.jump_flag_in & !fault_q;
  assign pop        = inst_valid & bus.inst_ready_in;

  assign outstanding_next = outstanding_q + {{AW{1'b0}}, req_fire} - {{AW{1'b0}}, resp_fire};

  assign bus.mem_req_valid_out = req_valid;
  assign bus.mem_req_addr_out  = pc_q;
  assign bus.inst_valid_out    = inst_valid;
  assign bus.inst_out          = fifo_inst_q[rd_ptr_q];
  assign bus.inst_addr_out     = fifo_addr_q[rd_ptr_q];
  assign bus.fault_out         = fault_q;

  // Control state: PC, response-address tracker, FIFO pointers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      fault_q       <= 1'b0;
    end else begin
      outstanding_q <= outstanding_next;
      fault_q       <= fault_q | misaligned;
      if (bus.jump_flag_in) begin
        // Redirect: empty the buffer and owe a drop for every word still
        // in flight after this edge.
        pc_q      <= jump_target;
        resp_pc_q <= jump_target;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        drop_q    <= outstanding_next;
      end else begin
        if (req_fire) begin
          pc_q <= pc_q + 32'd4;
        end
        if (push) begin
          wr_ptr_q  <= wr_ptr_q + 1'b1;
          resp_pc_q <= resp_pc_q + 32'd4;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        if (resp_fire && (drop_q != '0)) begin
          drop_q <= drop_q - 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= bus.mem_resp_data_in;
      fifo_addr_q[wr_ptr_q] <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_core_ifu.sv
module tb_core_ifu;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  core_ifu_if bus ();

  core_ifu #(.RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int errors;
  int checks;
  int cyc;
  int req_count;
  int epoch;
  int first_valid_cyc;
  int valid_cnt;
  logic resp_en;
  logic seen_wrap;
  logic have_req;
  logic s_req_valid;
  logic s_inst_valid;
  logic [31:0] exp_req_addr;
  logic [31:0] last_req_addr;
  logic [31:0] pend_addr[$];
  int          pend_epoch[$];
  logic [63:0] exp_q[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] align_of(input logic [31:0] a);
`ifdef CORE_IFU_ALIGN_CHECK_EN
    return a;
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < pop_log.size()) return pop_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample DUT, advance the model.
  task automatic tick();
    logic [31:0] a;
    logic [63:0] e;
    int          ep;
    bus.mem_resp_valid_in = 1'b0;
    bus.mem_resp_data_in  = '0;
    if (!rst && resp_en && pend_addr.size() != 0) begin
      a  = pend_addr.pop_front();
      ep = pend_epoch.pop_front();
      bus.mem_resp_valid_in = 1'b1;
      bus.mem_resp_data_in  = word_of(a);
      if (ep == epoch && !bus.jump_flag_in) exp_q.push_back({a, word_of(a)});
    end
    #1;
    s_req_valid  = bus.mem_req_valid_out;
    s_inst_valid = bus.inst_valid_out;
    if (s_inst_valid) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (s_req_valid && bus.mem_req_ready_in) begin
      check("req_addr", {32'h0, bus.mem_req_addr_out}, {32'h0, exp_req_addr});
      if (have_req && last_req_addr == 32'hFFFF_FFFC && bus.mem_req_addr_out == 32'h0)
        seen_wrap = 1'b1;
      last_req_addr = bus.mem_req_addr_out;
      have_req      = 1'b1;
      exp_req_addr  = exp_req_addr + 32'd4;
      pend_addr.push_back(bus.mem_req_addr_out);
      pend_epoch.push_back(epoch);
      req_count++;
    end
    if (s_inst_valid && bus.inst_ready_in) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      check("pop", {bus.inst_addr_out, bus.inst_out}, e);
      pop_log.push_back(bus.inst_addr_out);
    end
    if (bus.jump_flag_in && !rst) begin
      epoch++;
      exp_q.delete();
      exp_req_addr = align_of(bus.jump_addr_in);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.jump_flag_in = 1'b0;
    bus.hold_flag_in = 1'b0;
    ticks(2);
    check("rst_req_valid", {63'h0, bus.mem_req_valid_out}, 64'd0);
    check("rst_inst_valid", {63'h0, bus.inst_valid_out}, 64'd0);
    check("rst_fault", {63'h0, bus.fault_out}, 64'd0);
    pend_addr.delete();
    pend_epoch.delete();
    exp_q.delete();
    pop_log.delete();
    epoch++;
    exp_req_addr    = RESET_PC;
    req_count       = 0;
    first_valid_cyc = -1;
    valid_cnt       = 0;
    have_req        = 1'b0;
    rst = 1'b0;
  endtask

  task automatic do_jump(input logic [31:0] target);
    bus.jump_flag_in = 1'b1;
    bus.jump_addr_in = target;
    tick();
    bus.jump_flag_in = 1'b0;
    check("jump_no_req", {63'h0, s_req_valid}, 64'd0);
    check("jump_no_inst", {63'h0, s_inst_valid}, 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rel;
    int r;
    errors = 0;
    checks = 0;
    cyc    = 0;
    epoch  = 0;
    rst    = 1'b1;
    resp_en   = 1'b1;
    seen_wrap = 1'b0;
    bus.jump_flag_in      = 1'b0;
    bus.jump_addr_in      = '0;
    bus.hold_flag_in      = 1'b0;
    bus.mem_req_ready_in  = 1'b1;
    bus.mem_resp_valid_in = 1'b0;
    bus.mem_resp_data_in  = '0;
    bus.inst_ready_in     = 1'b1;
    @(posedge clk);
    #1;

    // Streaming fetch with 1-cycle memory and decode always ready.
    do_reset();
    rel = cyc;
    ticks(10);
    check("first_valid_latency", 64'(first_valid_cyc - rel), 64'd2);
    check("stream_reqs", 64'(req_count), 64'd10);
    check("stream_pops", 64'(pop_log.size()), 64'd8);
    check("stream_pop2", {32'h0, log_at(2)}, 64'h8);

    // Decode stalled: credit caps fetches at FIFO_DEPTH.
    do_reset();
    bus.inst_ready_in = 1'b0;
    ticks(8);
    check("stall_reqs", 64'(req_count), 64'd4);
    check("stall_req_valid", {63'h0, bus.mem_req_valid_out}, 64'd0);
    check("stall_inst_valid", {63'h0, bus.inst_valid_out}, 64'd1);
    check("stall_no_pops", 64'(pop_log.size()), 64'd0);
    bus.inst_ready_in = 1'b1;
    ticks(2);
    check("resume_reqs", 64'(req_count), 64'd5);
    check("resume_addr", {32'h0, last_req_addr}, 64'h10);
    ticks(6);
    check("resume_pop0", {32'h0, log_at(0)}, 64'h0);
    check("resume_pop3", {32'h0, log_at(3)}, 64'hC);

    // Redirect with buffered words and two fetches in flight.
    do_reset();
    bus.inst_ready_in = 1'b0;
    ticks(3);
    resp_en = 1'b0;
    tick();
    bus.inst_ready_in = 1'b1;
    pop_log.delete();
    do_jump(32'h0000_0100);
    check("flush_empty", {63'h0, bus.inst_valid_out}, 64'd0);
    resp_en = 1'b1;
    tick();
    check("jump_first_req", {32'h0, last_req_addr}, 64'h100);
    ticks(8);
    check("jump_first_pop", {32'h0, log_at(0)}, 64'h100);

    // Hold with responses in flight: no requests, responses still drain.
    resp_en = 1'b0;
    tick();
    bus.hold_flag_in = 1'b1;
    resp_en = 1'b1;
    r = req_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_no_req", {63'h0, s_req_valid}, 64'd0);
    end
    check("hold_req_count", 64'(req_count), 64'(r));
    check("hold_drained", 64'(exp_q.size()), 64'd0);
    check("hold_inst_valid", {63'h0, bus.inst_valid_out}, 64'd0);
    bus.hold_flag_in = 1'b0;
    tick();
    check("hold_resume", 64'(req_count), 64'(r + 1));

    // PC wrap at the top of the address space.
    pop_log.delete();
    seen_wrap = 1'b0;
    do_jump(32'hFFFF_FFF8);
    ticks(10);
    check("wrap_req", {63'h0, seen_wrap}, 64'd1);
    check("wrap_pop0", {32'h0, log_at(0)}, 64'hFFFF_FFF8);
    check("wrap_pop2", {32'h0, log_at(2)}, 64'h0);

    // Misaligned redirect.
    pop_log.delete();
`ifdef CORE_IFU_ALIGN_CHECK_EN
    do_jump(32'h0000_0102);
    check("fault_set", {63'h0, bus.fault_out}, 64'd1);
    r = req_count;
    valid_cnt = 0;
    ticks(6);
    check("fault_no_req", 64'(req_count), 64'(r));
    check("fault_no_inst", 64'(valid_cnt), 64'd0);
    check("fault_sticky", {63'h0, bus.fault_out}, 64'd1);
`else
    do_jump(32'h0000_0102);
    check("noalign_fault", {63'h0, bus.fault_out}, 64'd0);
    tick();
    check("noalign_req", {32'h0, last_req_addr}, 64'h100);
    ticks(8);
    check("noalign_pop0", {32'h0, log_at(0)}, 64'h100);
`endif

    // Reset clears everything, including a sticky fault.
    do_reset();
    ticks(4);
    check("post_reset_pop0", {32'h0, log_at(0)}, {32'h0, RESET_PC});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
